// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle mul and data-memory wait.
// Optional perf counters (StallCycles, FlushCount) are built when HAZ_PERF_CNT_EN is defined.
module hazard_controller #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [5:0] ID_opcode,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_rDestSelected,
  input  logic       EX_BranchTaken,
  input  logic       MEM_MemRead,
  input  logic       MEM_MemWrite,
  input  logic       DMemReady,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IDEX_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic       EXMEM_Bubble,
  output logic       BackEndHold,
  output logic [1:0] State
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] StallCycles,
  output logic [7:0]  FlushCount
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_MUL   = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] mul_cnt;
  logic [3:0] mul_cnt_d;

  logic   mem_stall;
  logic   rt_used;
  logic   load_use;
  logic   wait_hold;
  state_t eval_state;
  logic   eval_stall;
  logic   branch_flush;

  assign mem_stall = (MEM_MemRead | MEM_MemWrite) & ~DMemReady;

  // Only these formats actually read rt as a source operand.
  assign rt_used = (ID_opcode == OP_RTYPE) || (ID_opcode == OP_MUL) ||
                   (ID_opcode == OP_SW)    || (ID_opcode == OP_BEQ) ||
                   (ID_opcode == OP_BNE);

  assign load_use = EX_MemRead && (EX_rDestSelected != 5'd0) &&
                    ((EX_rDestSelected == ID_rs) ||
                     (rt_used && (EX_rDestSelected == ID_rt)));

  // A completed memory wait resumes as whichever state it interrupted.
  always_comb begin
    wait_hold  = 1'b0;
    eval_state = RUN;
    eval_stall = mem_stall;
    case (state_q)
      MUL_BUSY: eval_state = MUL_BUSY;
      MEM_WAIT: begin
        wait_hold  = ~DMemReady;
        eval_state = (mul_cnt != 4'd0) ? MUL_BUSY : RUN;
        eval_stall = 1'b0;
      end
      default: eval_state = RUN;
    endcase
  end

  always_comb begin
    PCWrite      = 1'b0;
    IFID_Write   = 1'b0;
    IDEX_Write   = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    EXMEM_Bubble = 1'b0;
    BackEndHold  = 1'b0;
    branch_flush = 1'b0;
    state_d      = state_q;
    mul_cnt_d    = mul_cnt;

    if (Rst) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
      state_d    = RUN;
      mul_cnt_d  = 4'd0;
    end else if (wait_hold) begin
      BackEndHold = 1'b1;
      state_d     = MEM_WAIT;
    end else if (eval_state == MUL_BUSY) begin
      if (eval_stall) begin
        BackEndHold = 1'b1;
        state_d     = MEM_WAIT;
      end else begin
        EXMEM_Bubble = 1'b1;
        mul_cnt_d    = mul_cnt - 4'd1;
        state_d      = (mul_cnt == 4'd1) ? RUN : MUL_BUSY;
      end
    end else if (eval_stall) begin
      BackEndHold = 1'b1;
      state_d     = MEM_WAIT;
    end else if (EX_BranchTaken) begin
      PCWrite      = 1'b1;
      IFID_Write   = 1'b1;
      IDEX_Write   = 1'b1;
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
      branch_flush = 1'b1;
      state_d      = RUN;
    end else if (load_use) begin
      IDEX_Write = 1'b1;
      IDEX_Flush = 1'b1;
      state_d    = RUN;
    end else begin
      PCWrite    = 1'b1;
      IFID_Write = 1'b1;
      IDEX_Write = 1'b1;
      state_d    = RUN;
      if ((ID_opcode == OP_MUL) && (MUL_LAT > 1)) begin
        mul_cnt_d = MUL_INIT;
        state_d   = MUL_BUSY;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RUN;
      mul_cnt <= 4'd0;
    end else begin
      state_q <= state_d;
      mul_cnt <= mul_cnt_d;
    end
  end

  assign State = state_q;

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst) begin
      StallCycles <= 16'd0;
      FlushCount  <= 8'd0;
    end else begin
      if (!PCWrite) StallCycles <= sat_inc16(StallCycles);
      if (branch_flush) FlushCount <= sat_inc8(FlushCount);
    end
  end
`endif

endmodule
